// File: rtl/memory_address_unit.sv
// memory_address_unit: memory address register with parallel load, stride
// increment/decrement and an autonomous strided burst that presents each
// address to the memory side over a valid/ready handshake.
// Optional feature macro: MAU_BOUNDS_CHECK_EN adds a limit input and a sticky
// fault output that flags any step result above limit or any wrapping step.
module memory_address_unit #(
  parameter int ADDR_WIDTH   = 8,
  parameter int STRIDE_WIDTH = 4,
  parameter int BURST_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [ADDR_WIDTH-1:0]   address_in,
  input  logic                    inc,
  input  logic                    dec,
  input  logic [STRIDE_WIDTH-1:0] stride,
  input  logic                    burst_start,
  input  logic [BURST_WIDTH-1:0]  burst_len,
  input  logic                    addr_ready,
`ifdef MAU_BOUNDS_CHECK_EN
  input  logic [ADDR_WIDTH-1:0]   limit,
  output logic                    fault,
`endif
  output logic [ADDR_WIDTH-1:0]   address_out,
  output logic                    addr_valid,
  output logic                    busy,
  output logic                    burst_done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]              state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   address_reg, address_next;
  logic [BURST_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [STRIDE_WIDTH-1:0] stride_reg, stride_next;
  logic                    done_reg, done_next;

  // During a burst the latched stride is used so live stride changes are ignored.
  logic [STRIDE_WIDTH-1:0] step_src;
  logic [ADDR_WIDTH-1:0]   step_ext;
  logic [ADDR_WIDTH-1:0]   sum_val;
  logic [ADDR_WIDTH-1:0]   diff_val;
  logic                    step_up;
  logic                    step_down;

  assign step_src = (state_reg == BURST) ? stride_reg : stride;
  assign step_ext = ADDR_WIDTH'(step_src);
  assign sum_val  = address_reg + step_ext;
  assign diff_val = address_reg - step_ext;

  // Next-state decode: IDLE commands by priority, BURST advances on handshake.
  always_comb begin
    state_next     = state_reg;
    address_next   = address_reg;
    remaining_next = remaining_reg;
    stride_next    = stride_reg;
    done_next      = 1'b0;
    step_up        = 1'b0;
    step_down      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          address_next = address_in;
        end else if (burst_start && (burst_len != '0)) begin
          state_next     = BURST;
          remaining_next = burst_len;
          stride_next    = stride;
        end else if (inc && !dec) begin
          address_next = sum_val;
          step_up      = 1'b1;
        end else if (dec && !inc) begin
          address_next = diff_val;
          step_down    = 1'b1;
        end
      end
      BURST: begin
        if (addr_ready) begin
          address_next   = sum_val;
          step_up        = 1'b1;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == BURST_WIDTH'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Architectural state; reset aborts any burst without a completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      address_reg   <= '0;
      remaining_reg <= '0;
      stride_reg    <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      address_reg   <= address_next;
      remaining_reg <= remaining_next;
      stride_reg    <= stride_next;
      done_reg      <= done_next;
    end
  end

`ifdef MAU_BOUNDS_CHECK_EN
  logic fault_reg, fault_next;
  logic carry_out, borrow_out;

  // Unsigned wrap detection without widening: an add wrapped if the result
  // dropped below the old address; a subtract borrowed if stride > address.
  assign carry_out  = (sum_val < address_reg);
  assign borrow_out = (address_reg < step_ext);

  // Sticky fault: cleared by a load, set by any out-of-range or wrapping step.
  always_comb begin
    fault_next = fault_reg;
    if ((state_reg == IDLE) && load) begin
      fault_next = 1'b0;
    end else if (step_up && (carry_out || (sum_val > limit))) begin
      fault_next = 1'b1;
    end else if (step_down && (borrow_out || (diff_val > limit))) begin
      fault_next = 1'b1;
    end
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fault_reg <= 1'b0;
    else        fault_reg <= fault_next;
  end

  assign fault = fault_reg;
`endif

  assign address_out = address_reg;
  assign addr_valid  = (state_reg == BURST);
  assign busy        = (state_reg == BURST);
  assign burst_done  = done_reg;

endmodule

// File: tb/tb_memory_address_unit.sv
// Self-checking bench for memory_address_unit (default 8/4/4 parameters).
// A behavioural model tracks address/burst progress with plain integer
// arithmetic; directed scenarios add literal expectations.
module tb_memory_address_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic [7:0] address_in = '0;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [3:0] stride = '0;
  logic       burst_start = 1'b0;
  logic [3:0] burst_len = '0;
  logic       addr_ready = 1'b0;
  logic [7:0] address_out;
  logic       addr_valid;
  logic       busy;
  logic       burst_done;
`ifdef MAU_BOUNDS_CHECK_EN
  logic [7:0] limit = '0;
  logic       fault;
`endif

  int checks = 0;
  int failures = 0;

  memory_address_unit #(.ADDR_WIDTH(8), .STRIDE_WIDTH(4), .BURST_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .address_in(address_in),
    .inc(inc), .dec(dec), .stride(stride), .burst_start(burst_start),
    .burst_len(burst_len), .addr_ready(addr_ready),
`ifdef MAU_BOUNDS_CHECK_EN
    .limit(limit), .fault(fault),
`endif
    .address_out(address_out), .addr_valid(addr_valid), .busy(busy),
    .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_addr = 0;
  int m_left = 0;      // addresses still to be handed out; >0 means bursting
  int m_stride = 0;
  int m_done = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_addr = 0; m_left = 0; m_stride = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        if (addr_ready) begin
          m_addr = (m_addr + m_stride) % 256;
          m_left = m_left - 1;
          if (m_left == 0) m_done = 1;
        end
      end else if (load) begin
        m_addr = int'(address_in);
      end else if (burst_start && burst_len != 0) begin
        m_left = int'(burst_len);
        m_stride = int'(stride);
      end else if (inc && !dec) begin
        m_addr = (m_addr + int'(stride)) % 256;
      end else if (dec && !inc) begin
        m_addr = (m_addr - int'(stride) + 256) % 256;
      end
    end
  end

  // Record every accepted burst address.
  logic [7:0] hs_q[$];
  always @(posedge clk) begin
    if (reset && addr_valid && addr_ready) hs_q.push_back(address_out);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (address_out != 8'(m_addr) || addr_valid != (m_left > 0) ||
        busy != (m_left > 0) || burst_done != (m_done != 0)) begin
      failures++;
      $display("FAIL model_cmp t=%0t got addr=%02h valid=%0b busy=%0b done=%0b want addr=%02h valid/busy=%0b done=%0b",
               $time, address_out, addr_valid, busy, burst_done, 8'(m_addr), (m_left > 0), m_done);
    end
  end

  // ---------------- helpers ----------------
  task automatic expect_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmds();
    load = 0; inc = 0; dec = 0; burst_start = 0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!burst_done && n < 40) begin
      tick();
      n++;
    end
    expect_val({name, "_done_seen"}, int'(burst_done), 1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    tick(); tick();
    expect_val("rst_addr", int'(address_out), 8'h00);
    expect_val("rst_valid", int'(addr_valid), 0);
    expect_val("rst_busy", int'(busy), 0);

    reset = 1;
    load = 1; address_in = 8'hAB;
    tick(); clear_cmds();
    expect_val("load_ab", int'(address_out), 8'hAB);
    tick();
    expect_val("hold_ab", int'(address_out), 8'hAB);

    load = 1; address_in = 8'hFE; tick(); clear_cmds();
    stride = 4'd3; inc = 1; tick(); clear_cmds();
    expect_val("inc_wrap", int'(address_out), 8'h01);
    dec = 1; tick(); clear_cmds();
    expect_val("dec_wrap", int'(address_out), 8'hFE);
    inc = 1; dec = 1; tick(); clear_cmds();
    expect_val("inc_dec_hold", int'(address_out), 8'hFE);

    // Full-speed burst, stride input changed mid-burst must not matter.
    load = 1; address_in = 8'h10; tick(); clear_cmds();
    hs_q.delete();
    stride = 4'd2; burst_len = 4'd4; burst_start = 1; addr_ready = 1;
    tick(); clear_cmds();
    expect_val("burst_first_valid", int'(addr_valid), 1);
    expect_val("burst_first_addr", int'(address_out), 8'h10);
    stride = 4'd7; burst_len = 4'd9;
    wait_done("burst1");
    expect_val("burst1_count", hs_q.size(), 4);
    for (int i = 0; i < hs_q.size() && i < 4; i++)
      expect_val($sformatf("burst1_addr%0d", i), int'(hs_q[i]), 8'h10 + 2 * i);
    expect_val("burst1_end_addr", int'(address_out), 8'h18);
    expect_val("burst1_end_busy", int'(busy), 0);
    tick();
    expect_val("burst1_done_clear", int'(burst_done), 0);

    // Zero-length burst is ignored while a same-cycle inc still applies.
    stride = 4'd1; burst_len = 4'd0; burst_start = 1; inc = 1;
    tick(); clear_cmds();
    expect_val("zero_len_inc", int'(address_out), 8'h19);
    expect_val("zero_len_busy", int'(busy), 0);

    // Burst with a two-cycle stall at 12 and a load attempt during it.
    load = 1; address_in = 8'h10; tick(); clear_cmds();
    hs_q.delete();
    stride = 4'd2; burst_len = 4'd4; burst_start = 1; addr_ready = 1;
    tick(); clear_cmds();
    tick();
    addr_ready = 0; load = 1; address_in = 8'h55;
    tick(); tick();
    expect_val("stall_addr", int'(address_out), 8'h12);
    expect_val("stall_valid", int'(addr_valid), 1);
    load = 0; addr_ready = 1;
    wait_done("burst2");
    expect_val("burst2_count", hs_q.size(), 4);
    for (int i = 0; i < hs_q.size() && i < 4; i++)
      expect_val($sformatf("burst2_addr%0d", i), int'(hs_q[i]), 8'h10 + 2 * i);
    expect_val("burst2_end_addr", int'(address_out), 8'h18);

    // Asynchronous reset between edges mid-burst.
    tick();
    stride = 4'd1; burst_len = 4'd5; burst_start = 1; addr_ready = 0;
    tick(); clear_cmds();
    expect_val("pre_abort_busy", int'(busy), 1);
    #2 reset = 0;
    #1;
    expect_val("abort_addr", int'(address_out), 8'h00);
    expect_val("abort_valid", int'(addr_valid), 0);
    expect_val("abort_busy", int'(busy), 0);
    tick();
    expect_val("abort_no_done", int'(burst_done), 0);
    reset = 1;
    load = 1; address_in = 8'h3C;
    tick(); clear_cmds();
    expect_val("first_cmd_after_rst", int'(address_out), 8'h3C);
    expect_val("post_rst_no_done", int'(burst_done), 0);

`ifdef MAU_BOUNDS_CHECK_EN
    limit = 8'h20;
    load = 1; address_in = 8'h1E; tick(); clear_cmds();
    expect_val("fault_after_load", int'(fault), 0);
    stride = 4'd4; inc = 1; tick(); clear_cmds();
    expect_val("bounds_addr", int'(address_out), 8'h22);
    expect_val("bounds_fault", int'(fault), 1);
    tick();
    expect_val("bounds_sticky", int'(fault), 1);
    load = 1; address_in = 8'h05; tick(); clear_cmds();
    expect_val("bounds_cleared", int'(fault), 0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout t=%0t got=running want=finished", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_address_unit.md
# memory_address_unit

Parametrised successor to the memory address register. It holds the current memory address and updates it by parallel load, stride increment/decrement, or an autonomous burst sequence. The burst sequence presents consecutive strided addresses to the memory side over a valid/ready handshake. It sits between the control unit (load/step/burst commands) and the memory port (address consumer).

## Interface
- ADDR_WIDTH, 8: address width in bits.
- STRIDE_WIDTH, 4: width of the unsigned stride operand, zero-extended to ADDR_WIDTH; STRIDE_WIDTH <= ADDR_WIDTH.
- BURST_WIDTH, 4: width of the burst length operand; maximum burst is 2^BURST_WIDTH-1 addresses.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  parallel load command.
- address_in  input  ADDR_WIDTH  value to load.
- inc  input  1  add stride to address.
- dec  input  1  subtract stride from address.
- stride  input  STRIDE_WIDTH  step size for inc/dec/burst.
- burst_start  input  1  begin a burst.
- burst_len  input  BURST_WIDTH  number of addresses in the burst.
- addr_ready  input  1  consumer accepts address_out this cycle.
- address_out  output  ADDR_WIDTH  current address (registered).
- addr_valid  output  1  address_out is a burst address awaiting acceptance.
- busy  output  1  burst in progress.
- burst_done  output  1  one-cycle pulse after the final burst handshake.

## Operation
- Two states: IDLE, BURST. Reset enters IDLE.
- Reset values: address_out=0, addr_valid=0, busy=0, burst_done=0, internal remaining count=0, latched stride=0.
- IDLE commands, priority load > burst_start > inc/dec:
  - load: address_out <= address_in.
  - burst_start with burst_len != 0: latch stride and burst_len; go to BURST. address_out is unchanged and is the first burst address.
  - burst_start with burst_len == 0: ignored. Lower-priority inc/dec in the same cycle still apply.
  - inc only: address_out <= address_out + stride, modulo 2^ADDR_WIDTH.
  - dec only: address_out <= address_out - stride, modulo 2^ADDR_WIDTH.
  - inc and dec together: hold.
  - No command: hold.
- BURST:
  - addr_valid=1, busy=1.
  - On addr_valid && addr_ready: address_out += latched stride (wrapping) and remaining -= 1.
  - On the handshake where remaining==1: go to IDLE and assert burst_done for the next cycle.
  - After a burst, address_out points one stride past the last burst address.
  - addr_ready low: address_out and remaining hold.
  - load, inc, dec and burst_start are ignored in BURST. Changes on stride/burst_len are ignored.
- burst_done is high for exactly one cycle, in IDLE, and is then cleared.

## Timing
- All outputs are registered. load/inc/dec take effect on the next rising edge (1-cycle latency).
- Burst of N addresses with addr_ready held high:
  - addr_valid rises the cycle after burst_start.
  - Exactly N handshakes occur in N consecutive cycles.
  - addr_valid and busy fall, and burst_done rises, on the edge of the Nth handshake.
- A new command is accepted in the same cycle burst_done is high.
- Reset assertion mid-operation clears all state immediately, without a clock edge, and aborts any burst with no burst_done.
- Deassertion is synchronised externally. The first command is honoured on the first edge after release.

## Configuration
- MAU_BOUNDS_CHECK_EN defined:
  - Adds input limit (ADDR_WIDTH) and output fault (1, sticky, reset 0).
  - fault sets on any inc, dec or burst step whose result exceeds limit, or whose arithmetic wraps (carry/borrow out).
  - The address still updates.
  - fault clears only on reset or load.
- MAU_BOUNDS_CHECK_EN undefined: no limit/fault ports; wrap-around is silent.

## Test plan
- Reset low -> address_out=00, addr_valid=0, busy=0. Release, load=1, address_in=AB -> address_out=AB next edge; holds AB with no command.
- address_out=FE, stride=3, inc one cycle -> 01 (wrap). Then dec one cycle -> FE. inc+dec together -> FE held.
- address_out=10, stride=2, burst_len=4, burst_start, addr_ready high -> valid addresses 10,12,14,16 on 4 consecutive cycles. Then address_out=18, busy=0, burst_done high one cycle.
- Same burst with addr_ready low two cycles at address 12 -> 12 held with addr_valid=1. load=1, address_in=55 during the burst -> ignored. Burst completes with 4 handshakes.
- Reset asserted mid-burst between edges -> address_out=00, addr_valid=0, busy=0 immediately; no burst_done.
- With MAU_BOUNDS_CHECK_EN, limit=20, address_out=1E, stride=4, inc -> address_out=22, fault=1 and stays 1. load of 05 -> fault=0.
